// File: rtl/branch_target_unit.sv
// ============================================================================
// Module   : branch_target_unit
// Purpose  : Relative-branch target evaluation with optional page-cross penalty
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_unit #(
    parameter int PAGE_PENALTY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       taken,
    input  logic [7:0] offset,
    input  logic [7:0] PCL_cur,
    input  logic [7:0] PCH_cur,
    output logic [7:0] PCL_in,
    output logic [7:0] PCH_in,
    output logic       load,
    output logic       busy,
    output logic       done,
    output logic       page_cross,
    output logic [1:0] extra_cycles
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        NOT_TAKEN = 3'd1,
        ADD_LO    = 3'd2,
        FIX_HI    = 3'd3,
        LOAD      = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_offset;
    logic [7:0] r_pcl;
    logic [7:0] r_pch;

    logic [8:0] w_sum;
    logic       w_carry;
    logic       w_cross;
    logic [7:0] w_pch_tgt;

    // Operands stay frozen after capture, so the sum is equally valid in FIX_HI.
    assign w_sum   = {1'b0, r_pcl} + {1'b0, r_offset};
    assign w_carry = w_sum[8];
    assign w_cross = w_carry ^ r_offset[7];

    always_comb begin
        w_pch_tgt = r_pch;
        if (w_carry && !r_offset[7]) begin
            w_pch_tgt = r_pch + 8'd1;
        end else if (!w_carry && r_offset[7]) begin
            w_pch_tgt = r_pch - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        load         = 1'b0;
        done         = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = taken ? ADD_LO : NOT_TAKEN;
                end
            end
            NOT_TAKEN: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            ADD_LO: begin
                if (!w_cross || (PAGE_PENALTY == 0)) begin
                    w_state_next = LOAD;
                end else begin
                    w_state_next = FIX_HI;
                end
            end
            FIX_HI: begin
                w_state_next = LOAD;
            end
            LOAD: begin
                load         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_offset     <= 8'h00;
            r_pcl        <= 8'h00;
            r_pch        <= 8'h00;
            PCL_in       <= 8'h00;
            PCH_in       <= 8'h00;
            page_cross   <= 1'b0;
            extra_cycles <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_offset <= offset;
                        r_pcl    <= PCL_cur;
                        r_pch    <= PCH_cur;
                        if (!taken) begin
                            page_cross   <= 1'b0;
                            extra_cycles <= 2'd0;
                        end
                    end
                end
                ADD_LO: begin
                    page_cross   <= w_cross;
                    extra_cycles <= w_cross ? 2'd2 : 2'd1;
                    // Target registers only move on the edge that enters LOAD.
                    if (w_state_next == LOAD) begin
                        PCL_in <= w_sum[7:0];
                        PCH_in <= w_pch_tgt;
                    end
                end
                FIX_HI: begin
                    PCL_in <= w_sum[7:0];
                    PCH_in <= w_pch_tgt;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_target_unit.sv
// ============================================================================
// Module   : tb_branch_target_unit
// Purpose  : Directed checks of branch_target_unit with both penalty settings
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_target_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       taken = 1'b0;
    logic [7:0] offset = 8'h00;
    logic [7:0] PCL_cur = 8'h00;
    logic [7:0] PCH_cur = 8'h00;

    logic [7:0] a_pcl, a_pch, b_pcl, b_pch;
    logic       a_load, a_busy, a_done, a_pc;
    logic       b_load, b_busy, b_done, b_pc;
    logic [1:0] a_ex, b_ex;

    int n_checks = 0;
    int n_errors = 0;

    int          lat_a, lat_b, loads_a, loads_b;
    logic [15:0] tgt_a, tgt_b;
    logic        pc_a, pc_b, busy_a1;
    logic [1:0]  ex_a, ex_b;

    branch_target_unit #(.PAGE_PENALTY(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .taken(taken), .offset(offset),
        .PCL_cur(PCL_cur), .PCH_cur(PCH_cur), .PCL_in(a_pcl), .PCH_in(a_pch),
        .load(a_load), .busy(a_busy), .done(a_done), .page_cross(a_pc),
        .extra_cycles(a_ex)
    );

    branch_target_unit #(.PAGE_PENALTY(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .taken(taken), .offset(offset),
        .PCL_cur(PCL_cur), .PCH_cur(PCH_cur), .PCL_in(b_pcl), .PCH_in(b_pch),
        .load(b_load), .busy(b_busy), .done(b_done), .page_cross(b_pc),
        .extra_cycles(b_ex)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Holding start for 'hold' edges also swaps in junk operands after the first.
    task automatic run_branch(input logic [15:0] pc, input logic [7:0] off,
                              input logic tk, input int hold);
        lat_a = 0; lat_b = 0; loads_a = 0; loads_b = 0;
        tgt_a = 16'h0; tgt_b = 16'h0; pc_a = 1'b0; pc_b = 1'b0;
        ex_a = 2'd3; ex_b = 2'd3; busy_a1 = 1'b0;
        @(negedge clk);
        PCH_cur = pc[15:8]; PCL_cur = pc[7:0]; offset = off; taken = tk; start = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (cyc == 1) busy_a1 = a_busy;
            if (cyc == 1 && hold > 1) begin
                PCH_cur = 8'h40; PCL_cur = 8'h00; offset = 8'h01; taken = 1'b1;
            end
            if (cyc >= hold) start = 1'b0;
            if (a_done && lat_a == 0) begin lat_a = cyc; pc_a = a_pc; ex_a = a_ex; end
            if (b_done && lat_b == 0) begin lat_b = cyc; pc_b = b_pc; ex_b = b_ex; end
            if (a_load) begin loads_a++; tgt_a = {a_pch, a_pcl}; end
            if (b_load) begin loads_b++; tgt_b = {b_pch, b_pcl}; end
        end
    endtask

    task automatic check_run(input string tag, input int e_lat_a, input int e_lat_b,
                             input logic [15:0] e_tgt, input logic e_pc,
                             input logic [1:0] e_ex, input logic tk);
        check_val({tag, "_busy"}, busy_a1, 1'b1);
        check_val({tag, "_lat_a"}, lat_a, e_lat_a);
        check_val({tag, "_lat_b"}, lat_b, e_lat_b);
        check_val({tag, "_pc_a"}, pc_a, e_pc);
        check_val({tag, "_pc_b"}, pc_b, e_pc);
        check_val({tag, "_ex_a"}, ex_a, e_ex);
        check_val({tag, "_ex_b"}, ex_b, e_ex);
        check_val({tag, "_loads_a"}, loads_a, tk ? 1 : 0);
        check_val({tag, "_loads_b"}, loads_b, tk ? 1 : 0);
        if (tk) begin
            check_val({tag, "_tgt_a"}, tgt_a, e_tgt);
            check_val({tag, "_tgt_b"}, tgt_b, e_tgt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;
        #12;
        check_val("rst_load", a_load, 1'b0);
        check_val("rst_done", a_done, 1'b0);
        check_val("rst_busy", a_busy, 1'b0);
        check_val("rst_target", {a_pch, a_pcl}, 16'h0000);
        check_val("rst_pc_ex", {a_pc, a_ex}, 3'b000);
        @(negedge clk);
        reset = 1'b1;

        run_branch(16'h1234, 8'h10, 1'b1, 1);
        check_run("fwd_nocross", 2, 2, 16'h1244, 1'b0, 2'd1, 1'b1);
        run_branch(16'h12F0, 8'h20, 1'b1, 1);
        check_run("fwd_cross", 3, 2, 16'h1310, 1'b1, 2'd2, 1'b1);
        run_branch(16'h1205, 8'hF0, 1'b1, 1);
        check_run("back_cross", 3, 2, 16'h11F5, 1'b1, 2'd2, 1'b1);
        run_branch(16'h1290, 8'hF0, 1'b1, 1);
        check_run("back_nocross", 2, 2, 16'h1280, 1'b0, 2'd1, 1'b1);
        run_branch(16'h1205, 8'h7F, 1'b0, 1);
        check_run("not_taken", 1, 1, 16'h0000, 1'b0, 2'd0, 1'b0);
        run_branch(16'hFFF0, 8'h20, 1'b1, 1);
        check_run("wrap_up", 3, 2, 16'h0010, 1'b1, 2'd2, 1'b1);
        run_branch(16'h0005, 8'h80, 1'b1, 1);
        check_run("wrap_down", 3, 2, 16'hFF85, 1'b1, 2'd2, 1'b1);
        run_branch(16'h12F0, 8'h20, 1'b1, 3);
        check_run("busy_ignore", 3, 2, 16'h1310, 1'b1, 2'd2, 1'b1);

        // Abort from FIX_HI: outputs must clear without waiting for a clock.
        @(negedge clk);
        PCH_cur = 8'h12; PCL_cur = 8'hF0; offset = 8'h20; taken = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        check_val("mid_busy", a_busy, 1'b1);
        reset = 1'b0;
        #1;
        check_val("mid_load", a_load, 1'b0);
        check_val("mid_done", a_done, 1'b0);
        check_val("mid_busy_clr", a_busy, 1'b0);
        check_val("mid_target", {a_pch, a_pcl}, 16'h0000);
        check_val("mid_pc_ex", {a_pc, a_ex}, 3'b000);
        l = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (a_load) l++;
        end
        check_val("mid_no_load", l, 0);
        reset = 1'b1;
        run_branch(16'h1234, 8'h10, 1'b1, 1);
        check_run("after_rst", 2, 2, 16'h1244, 1'b0, 2'd1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
